// File: rtl/ysyx_22040895_ctrl_if.sv
// Control-unit bus: decoded instruction fields, fetch/LSU handshakes,
// datapath strobes and status/counter outputs.
//
// Handshake: a request (ifu_req_o / lsu_req_o) stays high, unchanged,
// until the matching ready is seen high on a rising edge while the request
// is high; that edge completes the transfer. Ready seen in the same cycle
// the request first rises is accepted. Ready while no request is high is
// ignored.
`timescale 1ns/1ps
interface ysyx_22040895_ctrl_if;
    logic [6:0]  opcode_i;
    logic [2:0]  func3_i;
    logic [11:0] imm1_i;
    logic        ifu_req_o;
    logic        ifu_ready_i;
    logic        ir_we_o;
    logic        lsu_req_o;
    logic        lsu_we_o;
    logic        lsu_ready_i;
    logic        rf_we_o;
    logic        pc_we_o;
    logic        halt_o;
    logic [1:0]  halt_code_o;
    logic [2:0]  state_o;
    logic [63:0] cycle_cnt_o;
    logic [63:0] instret_o;

    // Controller side.
    modport master (
        input  opcode_i, func3_i, imm1_i, ifu_ready_i, lsu_ready_i,
        output ifu_req_o, ir_we_o, lsu_req_o, lsu_we_o, rf_we_o, pc_we_o,
        output halt_o, halt_code_o, state_o, cycle_cnt_o, instret_o
    );

    // Environment side (decode stage, fetch unit, LSU, observers).
    modport slave (
        output opcode_i, func3_i, imm1_i, ifu_ready_i, lsu_ready_i,
        input  ifu_req_o, ir_we_o, lsu_req_o, lsu_we_o, rf_we_o, pc_we_o,
        input  halt_o, halt_code_o, state_o, cycle_cnt_o, instret_o
    );
endinterface

// File: rtl/ysyx_22040895_ctrl.sv
// Multi-cycle core controller: FETCH -> DECODE -> EXEC -> (MEM) -> WB,
// with fetch/LSU wait timeouts, ebreak/illegal halts and 64-bit
// active-cycle and retired-instruction counters.
`timescale 1ns/1ps
module ysyx_22040895_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_22040895_ctrl_if.master    bus
);

    typedef enum logic [2:0] {
        S_RESET  = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101,
        S_HALT   = 3'b110,
        S_BAD    = 3'b111
    } state_e;

    localparam logic [1:0] HC_NONE    = 2'b00;
    localparam logic [1:0] HC_EBREAK  = 2'b01;
    localparam logic [1:0] HC_ILLEGAL = 2'b10;
    localparam logic [1:0] HC_TIMEOUT = 2'b11;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Timeout threshold widened by one bit so the wait+1 compare cannot wrap.
    localparam logic [8:0] TIMEOUT_LIM = MEM_TIMEOUT[8:0];

    state_e      state_q;
    logic [7:0]  wait_q;
    logic [1:0]  halt_code_q;
    logic        cls_mem_q;     // registered class: load or store
    logic        cls_store_q;   // registered class: store
    logic        cls_rf_q;      // registered class: writes the register file
    logic [63:0] cycle_cnt_q;
    logic [63:0] instret_q;

    logic        dec_legal_d;
    logic        dec_ebreak_d;
    logic        dec_mem_d;
    logic        dec_store_d;
    logic        dec_rf_d;
    logic [7:0]  wait_d;
    logic        wait_expired_d;
    logic        active_d;

    // Classify the instruction presented by the decode stage.
    always_comb begin
        dec_legal_d  = 1'b0;
        dec_ebreak_d = 1'b0;
        unique case (bus.opcode_i)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_IMM32, OP_REG32: dec_legal_d = 1'b1;
            OP_SYSTEM: dec_ebreak_d = (bus.func3_i == 3'b000) &&
                                      (bus.imm1_i == 12'h001);
            default: dec_legal_d = 1'b0;
        endcase
        dec_store_d = (bus.opcode_i == OP_STORE);
        dec_mem_d   = (bus.opcode_i == OP_LOAD) || dec_store_d;
        dec_rf_d    = !((bus.opcode_i == OP_BRANCH) || dec_store_d);
    end

    // Wait-cycle bookkeeping shared by the FETCH and MEM handshakes.
    always_comb begin
        wait_d         = wait_q + 8'd1;
        wait_expired_d = ({1'b0, wait_q} + 9'd1) >= TIMEOUT_LIM;
        active_d       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_EXEC)  || (state_q == S_MEM)    ||
                         (state_q == S_WB);
    end

    // Controller FSM, registered instruction class and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RESET;
            wait_q      <= 8'd0;
            halt_code_q <= HC_NONE;
            cls_mem_q   <= 1'b0;
            cls_store_q <= 1'b0;
            cls_rf_q    <= 1'b0;
            cycle_cnt_q <= 64'd0;
            instret_q   <= 64'd0;
        end else begin
            if (active_d) begin
                cycle_cnt_q <= cycle_cnt_q + 64'd1;
            end
            unique case (state_q)
                S_RESET: begin
                    state_q <= S_FETCH;
                    wait_q  <= 8'd0;
                end
                S_FETCH: begin
                    if (bus.ifu_ready_i) begin
                        state_q <= S_DECODE;
                    end else if (wait_expired_d) begin
                        state_q     <= S_HALT;
                        halt_code_q <= HC_TIMEOUT;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_DECODE: begin
                    if (dec_legal_d) begin
                        state_q     <= S_EXEC;
                        cls_mem_q   <= dec_mem_d;
                        cls_store_q <= dec_store_d;
                        cls_rf_q    <= dec_rf_d;
                    end else if (dec_ebreak_d) begin
                        state_q     <= S_HALT;
                        halt_code_q <= HC_EBREAK;
                    end else begin
                        state_q     <= S_HALT;
                        halt_code_q <= HC_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    if (cls_mem_q) begin
                        state_q <= S_MEM;
                        wait_q  <= 8'd0;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.lsu_ready_i) begin
                        state_q <= S_WB;
                    end else if (wait_expired_d) begin
                        state_q     <= S_HALT;
                        halt_code_q <= HC_TIMEOUT;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_WB: begin
                    state_q   <= S_FETCH;
                    wait_q    <= 8'd0;
                    instret_q <= instret_q + 64'd1;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q     <= S_HALT;
                    halt_code_q <= HC_ILLEGAL;
                end
            endcase
        end
    end

    // Strobes decode the registered state; only ir_we_o also looks at ready.
    assign bus.state_o     = state_q;
    assign bus.ifu_req_o   = (state_q == S_FETCH);
    assign bus.ir_we_o     = (state_q == S_FETCH) && bus.ifu_ready_i;
    assign bus.lsu_req_o   = (state_q == S_MEM);
    assign bus.lsu_we_o    = (state_q == S_MEM) && cls_store_q;
    assign bus.rf_we_o     = (state_q == S_WB) && cls_rf_q;
    assign bus.pc_we_o     = (state_q == S_WB);
    assign bus.halt_o      = (state_q == S_HALT);
    assign bus.halt_code_o = halt_code_q;
    assign bus.cycle_cnt_o = cycle_cnt_q;
    assign bus.instret_o   = instret_q;

endmodule
